// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the configurable UART transmitter and the
// matching receiver.
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - parity-mode encodings for the 2-bit cfg_parity field
//   - legal range of the runtime data-bit count
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // 2'b11 is decoded as "no parity", same as PAR_NONE.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: valid/ready word handshake between the upstream control
// logic and the UART transmitter.
//   in_valid  upstream -> tx   word present on data_in
//   in_ready  tx -> upstream   transmitter idle, word will be taken
//   data_in   upstream -> tx   word to send, bit 0 first
// master = upstream producer, slave = transmitter.
interface uart_tx_cfg_if #(
  parameter int NB_DATA = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [NB_DATA-1:0] data_in;

  modport master (output in_valid, output data_in, input in_ready);
  modport slave  (input in_valid, input data_in, output in_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter.
// Frame: start bit, 5..NB_DATA data bits LSB first, optional even/odd parity,
// 1 or 2 stop bits. Each bit lasts S_TICK pulses of s_tick.
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   s_tick        one-cycle oversampling pulse from the baud generator
//   up            word handshake (in_valid / in_ready / data_in), slave side
//   cfg_data_bits data-bit count, out-of-range values select NB_DATA
//   cfg_parity    00 none, 01 even, 10 odd, 11 none
//   cfg_stop2     0 one stop bit, 1 two stop bits
//   busy          frame in progress
//   tx_done_tick  one-cycle pulse on the first idle cycle after a frame
//   tx_serial     registered serial line, idles high
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int S_TICK  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_tick,
  uart_tx_cfg_if.slave        up,
  input  logic [3:0]          cfg_data_bits,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop2,
  output logic                busy,
  output logic                tx_done_tick,
  output logic                tx_serial
);

  localparam int TW = $clog2(2 * S_TICK);
  localparam int BW = $clog2(NB_DATA + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(S_TICK - 1);
  localparam logic [TW-1:0] TICK_LAST2 = TW'(2 * S_TICK - 1);

  logic [2:0]         state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic [3:0]         nbits_q, nbits_d;
  logic [1:0]         pmode_q, pmode_d;
  logic               stop2_q, stop2_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;

  logic [BW-1:0]      bit_last;
  logic               par_en;
  logic               par_odd;

  function automatic logic [3:0] clamp_bits(input logic [3:0] cfg);
    if (cfg < 4'(DATA_BITS_MIN) || cfg > 4'(NB_DATA)) begin
      return 4'(NB_DATA);
    end
    return cfg;
  endfunction

  // nbits_q is at least DATA_BITS_MIN after acceptance, so the subtraction
  // never underflows while in DATA.
  assign bit_last = BW'(nbits_q - 4'd1);
  assign par_en   = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
  assign par_odd  = (pmode_q == PAR_ODD);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    nbits_d = nbits_q;
    pmode_d = pmode_q;
    stop2_d = stop2_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        // s_tick on the acceptance edge is deliberately not counted.
        if (up.in_valid) begin
          state_d = ST_START;
          tick_d  = '0;
          shreg_d = up.data_in;
          nbits_d = clamp_bits(cfg_data_bits);
          pmode_d = cfg_parity;
          stop2_d = cfg_stop2;
          par_d   = 1'b0;
          tx_d    = 1'b0;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            state_d = ST_DATA;
            tick_d  = '0;
            bit_d   = '0;
            tx_d    = shreg_q[0];
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            // Running parity over exactly the bits that went out.
            par_d   = par_q ^ shreg_q[0];
            shreg_d = shreg_q >> 1;
            if (bit_q == bit_last) begin
              if (par_en) begin
                state_d = ST_PARITY;
                tx_d    = par_d ^ par_odd;
              end else begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              bit_d = bit_q + BW'(1);
              tx_d  = shreg_d[0];
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      ST_PARITY: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            state_d = ST_STOP;
            tick_d  = '0;
            tx_d    = 1'b1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          // Two stop bits are one double-length count, hence the wider counter.
          if (tick_q == (stop2_q ? TICK_LAST2 : TICK_LAST)) begin
            state_d = ST_IDLE;
            tick_d  = '0;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      nbits_q <= '0;
      pmode_q <= PAR_NONE;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      nbits_q <= nbits_d;
      pmode_q <= pmode_d;
      stop2_q <= stop2_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign up.in_ready  = (state_q == ST_IDLE);
  assign tx_serial    = tx_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

  localparam int CAPN = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic [3:0] cfg_data_bits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       busy;
  logic       tx_done_tick;
  logic       tx_serial;

  uart_tx_cfg_if #(.NB_DATA(8)) bus ();

  uart_tx_cfg #(.NB_DATA(8), .S_TICK(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_tick        (s_tick),
    .up            (bus.slave),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .busy          (busy),
    .tx_done_tick  (tx_done_tick),
    .tx_serial     (tx_serial)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   kcyc = 0;
  int   div_g = 1;
  logic cap [0:CAPN-1];

  // Advance to the next falling edge and drive s_tick for the coming edge.
  task automatic next_cycle();
    @(negedge clk);
    kcyc++;
    s_tick = (div_g == 1) ? 1'b1 : ((kcyc % div_g) == 0);
  endtask

  // Present a word; the following rising edge is the acceptance edge.
  task automatic start_word(input logic [7:0] d, input logic [3:0] nb,
                            input logic [1:0] p, input logic s2);
    @(negedge clk);
    kcyc = 0;
    s_tick = 1'b1;
    bus.in_valid = 1'b1;
    bus.data_in = d;
    cfg_data_bits = nb;
    cfg_parity = p;
    cfg_stop2 = s2;
  endtask

  // Record tx_serial for frame cycles 1..N; len = N when the done pulse is seen
  // in cycle N+1, -1 when the cycle budget expires.
  task automatic capture(input int maxc, input bit keep_valid, input bit swap,
                         input logic [7:0] d2, input logic [3:0] nb2,
                         input logic [1:0] p2, input logic s22, output int len);
    len = -1;
    for (int i = 0; i < CAPN; i++) cap[i] = 1'bx;
    for (int c = 1; c <= maxc; c++) begin
      next_cycle();
      if (c == 1) begin
        if (!keep_valid) bus.in_valid = 1'b0;
        if (swap) begin
          bus.data_in = d2;
          cfg_data_bits = nb2;
          cfg_parity = p2;
          cfg_stop2 = s22;
        end
      end
      if (c < CAPN) cap[c] = tx_serial;
      if (tx_done_tick === 1'b1) begin
        len = c - 1;
        break;
      end
    end
  endtask

  function automatic logic [15:0] mid_bits(input int p, input int nslots);
    logic [15:0] v = '0;
    for (int i = 0; i < nslots; i++) v[i] = cap[1 + i * p + p / 2];
    return v;
  endfunction

  function automatic int wave_errs(input logic [15:0] ev, input int p, input int len);
    int e = 0;
    for (int c = 1; c <= len && c < CAPN; c++)
      if (cap[c] !== ev[(c - 1) / p]) e++;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in = 8'h00;
    s_tick = 1'b0;
    cfg_data_bits = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_serial !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx_serial); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
    checks++; if (tx_done_tick !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", tx_done_tick); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    int len;
    int e;
    logic [15:0] m;
    div_g = 1;
    start_word(8'h55, 4'd8, 2'b00, 1'b0);
    capture(400, 1'b0, 1'b0, 8'h00, 4'd0, 2'b00, 1'b0, len);
    m = mid_bits(16, 10);
    e = wave_errs(16'h02AA, 16, len);
    checks++; if (len !== 160) begin failures++; $display("FAIL 8n1_len got=%0d exp=160", len); end
    checks++; if (m !== 16'h02AA) begin failures++; $display("FAIL 8n1_bits got=%h exp=02aa", m); end
    checks++; if (e !== 0) begin failures++; $display("FAIL 8n1_wave bad_cycles=%0d exp=0", e); end
    checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL 8n1_idle ready=%b busy=%b exp=1/0", bus.in_ready, busy); end
    next_cycle();
    checks++; if (tx_done_tick !== 1'b0) begin failures++; $display("FAIL 8n1_done_width got=%b exp=0", tx_done_tick); end
    checks++; if (tx_serial !== 1'b1) begin failures++; $display("FAIL 8n1_idle_line got=%b exp=1", tx_serial); end
  endtask

  task automatic test_formats();
    logic [7:0]  td [0:4] = '{8'h53, 8'hFF, 8'h1F, 8'hA5, 8'h3C};
    logic [3:0]  tn [0:4] = '{4'd7, 4'd8, 4'd5, 4'd3, 4'd12};
    logic [1:0]  tp [0:4] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    logic        ts [0:4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] tv [0:4] = '{16'h06A6, 16'h07FE, 16'h007E, 16'h034A, 16'h0278};
    int          tk [0:4] = '{11, 11, 7, 10, 10};
    div_g = 1;
    for (int t = 0; t < 5; t++) begin
      int len;
      int e;
      logic [15:0] m;
      start_word(td[t], tn[t], tp[t], ts[t]);
      capture(400, 1'b0, 1'b0, 8'h00, 4'd0, 2'b00, 1'b0, len);
      m = mid_bits(16, tk[t]);
      e = wave_errs(tv[t], 16, len);
      checks++; if (len !== tk[t] * 16) begin failures++; $display("FAIL fmt%0d_len got=%0d exp=%0d", t, len, tk[t] * 16); end
      checks++; if (m !== tv[t]) begin failures++; $display("FAIL fmt%0d_bits got=%h exp=%h", t, m, tv[t]); end
      checks++; if (e !== 0) begin failures++; $display("FAIL fmt%0d_wave bad_cycles=%0d exp=0", t, e); end
    end
  endtask

  task automatic test_tick_div();
    int len;
    int e;
    logic [15:0] m;
    div_g = 4;
    start_word(8'h55, 4'd8, 2'b00, 1'b0);
    capture(900, 1'b0, 1'b0, 8'h00, 4'd0, 2'b00, 1'b0, len);
    m = mid_bits(64, 10);
    e = wave_errs(16'h02AA, 64, len);
    checks++; if (len !== 640) begin failures++; $display("FAIL div4_len got=%0d exp=640", len); end
    checks++; if (m !== 16'h02AA) begin failures++; $display("FAIL div4_bits got=%h exp=02aa", m); end
    checks++; if (e !== 0) begin failures++; $display("FAIL div4_wave bad_cycles=%0d exp=0", e); end
    div_g = 1;
  endtask

  task automatic test_back_to_back();
    int len1;
    int len2;
    int e;
    logic [15:0] m;
    div_g = 1;
    start_word(8'h0F, 4'd8, 2'b00, 1'b0);
    // Second word and its config appear right after the first is taken.
    capture(400, 1'b1, 1'b1, 8'h81, 4'd5, 2'b01, 1'b0, len1);
    m = mid_bits(16, 10);
    e = wave_errs(16'h021E, 16, len1);
    checks++; if (len1 !== 160) begin failures++; $display("FAIL b2b1_len got=%0d exp=160", len1); end
    checks++; if (m !== 16'h021E) begin failures++; $display("FAIL b2b1_bits got=%h exp=021e", m); end
    checks++; if (e !== 0) begin failures++; $display("FAIL b2b1_wave bad_cycles=%0d exp=0", e); end
    capture(400, 1'b0, 1'b0, 8'h00, 4'd0, 2'b00, 1'b0, len2);
    m = mid_bits(16, 8);
    e = wave_errs(16'h00C2, 16, len2);
    checks++; if (cap[1] !== 1'b0) begin failures++; $display("FAIL b2b2_start got=%b exp=0", cap[1]); end
    checks++; if (len2 !== 128) begin failures++; $display("FAIL b2b2_len got=%0d exp=128", len2); end
    checks++; if (m !== 16'h00C2) begin failures++; $display("FAIL b2b2_bits got=%h exp=00c2", m); end
    checks++; if (e !== 0) begin failures++; $display("FAIL b2b2_wave bad_cycles=%0d exp=0", e); end
  endtask

  task automatic test_reset_mid();
    int len;
    int e;
    int dones = 0;
    int highs = 0;
    logic [15:0] m;
    div_g = 1;
    start_word(8'h55, 4'd8, 2'b00, 1'b0);
    for (int c = 1; c <= 70; c++) begin
      next_cycle();
      if (c == 1) bus.in_valid = 1'b0;
    end
    checks++; if (tx_serial !== 1'b0) begin failures++; $display("FAIL rst_bit3 got=%b exp=0", tx_serial); end
    #2 reset = 1'b1;
    #1;
    checks++; if (tx_serial !== 1'b1) begin failures++; $display("FAIL rst_async_tx got=%b exp=1", tx_serial); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      if (tx_done_tick !== 1'b0) dones++;
    end
    reset = 1'b0;
    for (int c = 0; c < 120; c++) begin
      next_cycle();
      if (tx_done_tick !== 1'b0) dones++;
      if (tx_serial !== 1'b1) highs++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL rst_no_done pulses=%0d exp=0", dones); end
    checks++; if (highs !== 0) begin failures++; $display("FAIL rst_line_idle low_cycles=%0d exp=0", highs); end
    start_word(8'hA5, 4'd8, 2'b00, 1'b0);
    capture(400, 1'b0, 1'b0, 8'h00, 4'd0, 2'b00, 1'b0, len);
    m = mid_bits(16, 10);
    e = wave_errs(16'h034A, 16, len);
    checks++; if (len !== 160) begin failures++; $display("FAIL rst_next_len got=%0d exp=160", len); end
    checks++; if (m !== 16'h034A) begin failures++; $display("FAIL rst_next_bits got=%h exp=034a", m); end
    checks++; if (e !== 0) begin failures++; $display("FAIL rst_next_wave bad_cycles=%0d exp=0", e); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_formats();
    test_tick_div();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
